// File: rtl/rv_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rv_wb_arbiter_if
// Brief    : Writeback bus bundle: ALU/LSU result inputs, register-file write
//            port, forwarding bus and LSU buffer occupancy.
// Revision : 1.0 - initial release
// ============================================================================
interface rv_wb_arbiter_if #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int LSU_FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;

    logic [REG_AW-1:0] rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              rf_we;

    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;

    logic [CNT_W-1:0]  lsu_fifo_count;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_rd, rf_wdata, rf_we,
        output fwd_valid, fwd_rd, fwd_data,
        output lsu_fifo_count
    );

    // Producer / observer side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_rd, rf_wdata, rf_we,
        input  fwd_valid, fwd_rd, fwd_data,
        input  lsu_fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_wb_arbiter
// Brief    : Writeback arbiter - merges ALU results with FIFO-buffered LSU
//            results into the single register-file write port, ALU priority
//            with a bounded starvation guard, plus a forwarding mirror.
// Revision : 1.0 - initial release
// ============================================================================
module rv_wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_AW         = 5,
    parameter int LSU_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    rv_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] c_FULL_CNT   = CNT_W'(LSU_FIFO_DEPTH);
    localparam logic [SC_W-1:0]  c_STARVE_MAX = SC_W'(STARVE_LIMIT);

    generate
        if (LSU_FIFO_DEPTH < 2 || (LSU_FIFO_DEPTH & (LSU_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rv_wb_arbiter: LSU_FIFO_DEPTH must be a power of two >= 2");
        end
        if (STARVE_LIMIT < 1) begin : g_bad_starve
            $error("rv_wb_arbiter: STARVE_LIMIT must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [REG_AW-1:0] r_mem_rd   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0]   r_mem_data [LSU_FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [SC_W-1:0]   r_starve;

    logic [REG_AW-1:0] r_rf_rd;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_rf_we;

    // ------------------------------------------------------------------------
    // Handshakes and arbitration
    // ------------------------------------------------------------------------
    logic              w_full;
    logic              w_nonempty;
    logic              w_alu_ready;
    logic              w_push;
    logic              w_alu_win;
    logic              w_pop;
    logic [REG_AW-1:0] w_head_rd;
    logic [XLEN-1:0]   w_head_data;
    logic [SC_W-1:0]   w_starve_nxt;

    assign w_full      = (r_count == c_FULL_CNT);
    assign w_nonempty  = (r_count != '0);
    assign w_alu_ready = !((r_starve == c_STARVE_MAX) && w_nonempty);

    // Fullness is judged on the registered count, so a same-cycle pop never
    // frees a slot for a push.
    assign w_push      = bus.lsu_valid && !w_full;
    assign w_alu_win   = bus.alu_valid && w_alu_ready;
    assign w_pop       = !w_alu_win && w_nonempty;

    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    always_comb begin
        w_starve_nxt = r_starve;
        if (!w_nonempty || w_pop) begin
            w_starve_nxt = '0;
        end else if (w_alu_win && (r_starve != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // LSU result buffer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= bus.lsu_rd;
            r_mem_data[r_wr_ptr] <= bus.lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            r_starve <= w_starve_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Write-port register; x0 destinations are consumed without a write
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
            r_rf_we    <= 1'b0;
        end else if (w_alu_win) begin
            r_rf_rd    <= bus.alu_rd;
            r_rf_wdata <= bus.alu_data;
            r_rf_we    <= (bus.alu_rd != '0);
        end else if (w_pop) begin
            r_rf_rd    <= w_head_rd;
            r_rf_wdata <= w_head_data;
            r_rf_we    <= (w_head_rd != '0);
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.alu_ready      = w_alu_ready;
    assign bus.lsu_ready      = !w_full;
    assign bus.rf_rd          = r_rf_rd;
    assign bus.rf_wdata       = r_rf_wdata;
    assign bus.rf_we          = r_rf_we;
    assign bus.fwd_valid      = r_rf_we;
    assign bus.fwd_rd         = r_rf_rd;
    assign bus.fwd_data       = r_rf_wdata;
    assign bus.lsu_fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rv_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_wb_arbiter
// Brief    : Scenario bench for rv_wb_arbiter with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_wb_arbiter;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 4;
    localparam int SLIM   = 3;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    wr_t  lsu_q[$];
    bit   alu_pend;
    wr_t  alu_pend_w;

    rv_wb_arbiter_if #(.XLEN(XLEN), .REG_AW(REG_AW), .LSU_FIFO_DEPTH(DEPTH)) bus ();

    rv_wb_arbiter #(
        .XLEN           (XLEN),
        .REG_AW         (REG_AW),
        .LSU_FIFO_DEPTH (DEPTH),
        .STARVE_LIMIT   (SLIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Scoreboard: accepted ALU results are due the next cycle; LSU results
    // are queued at acceptance and must emerge in order when no ALU is due.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_vec++;
            if (bus.rf_we !== 1'b0 || bus.lsu_fifo_count !== '0) begin
                n_err++;
                $display("FAIL in_reset: rf_we=%b count=%0d, required 0/0", bus.rf_we, bus.lsu_fifo_count);
            end
            lsu_q.delete();
            alu_pend = 1'b0;
        end else begin
            if (alu_pend) begin
                n_vec++;
                if (alu_pend_w.rd == '0) begin
                    if (bus.rf_we !== 1'b0 || bus.fwd_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL alu_x0_write: rf_we=%b fwd_valid=%b, required 0", bus.rf_we, bus.fwd_valid);
                    end
                end else if (bus.rf_we !== 1'b1 || bus.rf_rd !== alu_pend_w.rd || bus.rf_wdata !== alu_pend_w.data
                             || bus.fwd_valid !== 1'b1 || bus.fwd_rd !== alu_pend_w.rd || bus.fwd_data !== alu_pend_w.data) begin
                    n_err++;
                    $display("FAIL alu_write: we=%b rd=%0d data=%h fwd=%b/%0d/%h, required 1 rd=%0d data=%h",
                             bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.fwd_valid, bus.fwd_rd, bus.fwd_data,
                             alu_pend_w.rd, alu_pend_w.data);
                end
            end else if (bus.rf_we === 1'b1) begin
                n_vec++;
                if (lsu_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: rd=%0d data=%h, required no write", bus.rf_rd, bus.rf_wdata);
                end else begin
                    wr_t e;
                    e = lsu_q.pop_front();
                    if (bus.rf_rd !== e.rd || bus.rf_wdata !== e.data || bus.fwd_valid !== 1'b1
                        || bus.fwd_rd !== e.rd || bus.fwd_data !== e.data) begin
                        n_err++;
                        $display("FAIL lsu_write: rd=%0d data=%h fwd=%b/%0d/%h, required rd=%0d data=%h",
                                 bus.rf_rd, bus.rf_wdata, bus.fwd_valid, bus.fwd_rd, bus.fwd_data, e.rd, e.data);
                    end
                end
            end else if (bus.rf_we !== 1'b0) begin
                n_vec++;
                n_err++;
                $display("FAIL rf_we_unknown: rf_we=%b, required 0 or 1", bus.rf_we);
            end
            alu_pend   = bus.alu_valid && bus.alu_ready;
            alu_pend_w = '{rd: bus.alu_rd, data: bus.alu_data};
            if (bus.lsu_valid && bus.lsu_ready) begin
                lsu_q.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
            end
        end
    end

    task automatic bus_idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = '0;
        bus.lsu_data  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b0 || bus.rf_rd !== '0 || bus.rf_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_rf: we=%b rd=%0d data=%h, required 0/0/0", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        n_vec++;
        if (bus.fwd_valid !== 1'b0 || bus.fwd_rd !== '0 || bus.fwd_data !== '0) begin
            n_err++;
            $display("FAIL reset_fwd: %b/%0d/%h, required 0/0/0", bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
        end
        n_vec++;
        if (bus.lsu_fifo_count !== '0 || bus.lsu_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_fifo: count=%0d lsu_ready=%b alu_ready=%b, required 0/1/1",
                     bus.lsu_fifo_count, bus.lsu_ready, bus.alu_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_basic();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd4;
        bus.alu_data  = 32'h01;
        @(negedge clk);
        n_vec++;
        if (bus.alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL alu_basic_ready: %b, required 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        bus.alu_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd4 || bus.rf_wdata !== 32'h01 || bus.fwd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL alu_basic_write: we=%b rd=%0d data=%h fwd=%b, required 1/4/01/1",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.fwd_valid);
        end
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL alu_basic_drop: rf_we=%b, required 0", bus.rf_we);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lsu_basic();
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd5;
        bus.lsu_data  = 32'h77;
        @(negedge clk);
        n_vec++;
        if (bus.lsu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lsu_basic_ready: %b, required 1", bus.lsu_ready);
        end
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.lsu_fifo_count !== 3'd1 || bus.rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL lsu_basic_queued: count=%0d we=%b, required 1/0", bus.lsu_fifo_count, bus.rf_we);
        end
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_wdata !== 32'h77 || bus.lsu_fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL lsu_basic_write: we=%b rd=%0d data=%h count=%0d, required 1/5/77/0",
                     bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.lsu_fifo_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd2;
        bus.alu_data  = 32'h11;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd3;
        bus.lsu_data  = 32'h22;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd2 || bus.rf_wdata !== 32'h11) begin
            n_err++;
            $display("FAIL simul_first: we=%b rd=%0d data=%h, required 1/2/11", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wdata !== 32'h22) begin
            n_err++;
            $display("FAIL simul_second: we=%b rd=%0d data=%h, required 1/3/22", bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        bit     exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit     acc;
        int     k = 0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd7;
        bus.lsu_data  = 32'h5A5A_0007;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd8;
        bus.alu_data  = $urandom;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (bus.alu_ready !== exp_rdy[c]) begin
                n_err++;
                $display("FAIL starve_ready[%0d]: alu_ready=%b, required %b", c, bus.alu_ready, exp_rdy[c]);
            end
            if (c == 4) begin
                n_vec++;
                if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.lsu_fifo_count !== 3'd0) begin
                    n_err++;
                    $display("FAIL starve_pop: we=%b rd=%0d count=%0d, required 1/7/0",
                             bus.rf_we, bus.rf_rd, bus.lsu_fifo_count);
                end
            end
            acc = bus.alu_valid && bus.alu_ready;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                bus.alu_rd   = REG_AW'(8 + k);
                bus.alu_data = $urandom;
            end
        end
        bus_idle();
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_fifo_full();
        bit   exp_lrdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit   exp_ardy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_cnt  [6] = '{0, 1, 2, 3, 4, 3};
        bit   a_acc;
        bit   l_acc;
        int   pushes = 0;
        int   k = 0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd16;
        bus.alu_data  = $urandom;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd24;
        bus.lsu_data  = 32'hC000_0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) begin
                n_vec++;
                if (bus.lsu_ready !== exp_lrdy[c] || bus.alu_ready !== exp_ardy[c]
                    || bus.lsu_fifo_count !== 3'(exp_cnt[c])) begin
                    n_err++;
                    $display("FAIL full_cycle[%0d]: lsu_ready=%b alu_ready=%b count=%0d, required %b/%b/%0d",
                             c, bus.lsu_ready, bus.alu_ready, bus.lsu_fifo_count, exp_lrdy[c], exp_ardy[c], exp_cnt[c]);
                end
            end else if (c == 6) begin
                n_vec++;
                if (bus.lsu_fifo_count !== 3'd4) begin
                    n_err++;
                    $display("FAIL full_refill: count=%0d, required 4", bus.lsu_fifo_count);
                end
            end
            a_acc = bus.alu_valid && bus.alu_ready;
            l_acc = bus.lsu_valid && bus.lsu_ready;
            @(posedge clk); #1;
            if (a_acc) begin
                k++;
                bus.alu_rd   = REG_AW'(16 + (k % 8));
                bus.alu_data = $urandom;
            end
            if (l_acc) begin
                pushes++;
                bus.lsu_rd   = REG_AW'(24 + pushes);
                bus.lsu_data = 32'hC000_0000 + 32'(pushes);
                if (pushes == 5) bus.lsu_valid = 1'b0;
            end
        end
        bus_idle();
        repeat (6) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.lsu_fifo_count !== 3'd0 || lsu_q.size() != 0 || pushes != 5) begin
            n_err++;
            $display("FAIL full_drain: count=%0d pending=%0d pushes=%0d, required 0/0/5",
                     bus.lsu_fifo_count, lsu_q.size(), pushes);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_x0();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'hFF;
        @(negedge clk);
        n_vec++;
        if (bus.alu_ready !== 1'b1) begin
            n_err++;
            $display("FAIL x0_ready: %b, required 1", bus.alu_ready);
        end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        n_vec++;
        if (bus.rf_we !== 1'b0 || bus.fwd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL x0_we: rf_we=%b fwd_valid=%b, required 0/0", bus.rf_we, bus.fwd_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd12;
        bus.alu_data  = $urandom;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd13;
        bus.lsu_data  = 32'hD00D_0013;
        @(posedge clk); #1;
        bus.alu_data  = $urandom;
        bus.lsu_rd    = 5'd14;
        bus.lsu_data  = 32'hD00D_0014;
        @(posedge clk); #1;
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.lsu_fifo_count !== 3'd2 || bus.rf_we !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: count=%0d we=%b, required 2/1", bus.lsu_fifo_count, bus.rf_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.rf_we !== 1'b0 || bus.lsu_fifo_count !== '0 || bus.fwd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: we=%b count=%0d fwd=%b, required 0/0/0",
                     bus.rf_we, bus.lsu_fifo_count, bus.fwd_valid);
        end
        bus_idle();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++;
        if (bus.lsu_fifo_count !== 3'd0 || bus.rf_we !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_after: count=%0d we=%b, required 0/0", bus.lsu_fifo_count, bus.rf_we);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        alu_pend = 1'b0;
        rst_n    = 1'b0;
        bus_idle();
        test_reset();
        test_alu_basic();
        test_lsu_basic();
        test_simultaneous();
        test_starvation();
        test_fifo_full();
        test_x0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
